midi_voice_allocator: RTL and testbench

- Sits downstream of the UART/MIDI byte deserializer and schedules the synth's shared voice slots.
- Parses the byte stream, with running status, into Note On/Note Off events for one MIDI channel.
- Assigns each note to one of NUM_VOICES voice slots: retrigger if the note is already held, else the first free slot, else steal the oldest.
- Drives per-voice note/velocity/active/trigger to the oscillator bank.

---
 rtl/midi_voice_allocator.sv | 225 ++++++++++++++++++++++
 tb/tb_midi_voice_allocator.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator
//   Parses a MIDI byte stream (running status, realtime bytes transparent)
//   into Note On / Note Off events for one channel and assigns each note to
//   one of NUM_VOICES voice slots: retrigger a held note, else the lowest
//   free slot, else steal the oldest slot (ties to the lowest index).
//
//   Optional build macro: SUSTAIN_PEDAL_EN enables the sustain pedal
//   (Control Change 64). Without it every Control Change is discarded.
//
// Ports
//   clock           system clock
//   reset           synchronous, active-low reset
//   byte_valid      one-cycle strobe, midi_byte valid
//   midi_byte[7:0]  received MIDI byte
//   busy            high while an event is being scheduled
//   overflow        one-cycle pulse when a non-realtime byte is dropped while busy
//   voice_active    bit i = voice i sounding
//   voice_note      note of voice i at [7i+6:7i]
//   voice_velocity  velocity of voice i, same packing
//   voice_trigger   one-cycle pulse for a voice started, retriggered or stolen
//
// state     | meaning
// ----------+-----------------------------------------------------------
// NO_STATUS | no running status; data bytes ignored
// WAIT_D1   | running status held, waiting for first data byte
// WAIT_D2   | waiting for second data byte
// EXEC      | scheduler: scan one voice per cycle, then one commit cycle

module midi_voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int CHANNEL    = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    byte_valid,
    input  logic [7:0]              midi_byte,
    output logic                    busy,
    output logic                    overflow,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic [7*NUM_VOICES-1:0] voice_note,
    output logic [7*NUM_VOICES-1:0] voice_velocity,
    output logic [NUM_VOICES-1:0]   voice_trigger
);
    localparam int VIDX_W = $clog2(NUM_VOICES);
    localparam int SCAN_W = $clog2(NUM_VOICES + 1);
    localparam logic [VIDX_W-1:0] AGE_MAX   = VIDX_W'(NUM_VOICES - 1);
    localparam logic [SCAN_W-1:0] SCAN_DONE = SCAN_W'(NUM_VOICES);
    localparam logic [3:0]        CH        = 4'(CHANNEL);

    typedef enum logic [1:0] {NO_STATUS, WAIT_D1, WAIT_D2, EXEC} state_t;

    state_t            state;
    logic [7:0]        status;
    logic [6:0]        d1;
    logic [6:0]        d2;
    logic [SCAN_W-1:0] scan_idx;
    logic [VIDX_W-1:0] scan_v;
    logic              match_found;
    logic              free_found;
    logic [VIDX_W-1:0] match_idx;
    logic [VIDX_W-1:0] free_idx;
    logic [VIDX_W-1:0] old_idx;
    logic [VIDX_W-1:0] old_age;
    logic [VIDX_W-1:0] chosen;
    logic              note_on;
    logic              cc_exec;
    logic [6:0]        note_q [NUM_VOICES];
    logic [6:0]        vel_q  [NUM_VOICES];
    logic [VIDX_W-1:0] age_q  [NUM_VOICES];
`ifdef SUSTAIN_PEDAL_EN
    logic                  pedal_down;
    logic [NUM_VOICES-1:0] sustained;
`endif

    assign scan_v  = scan_idx[VIDX_W-1:0];
    // Status is frozen during EXEC, so the event kind is decoded from it.
    assign note_on = (status[7:4] == 4'h9) && (d2 != 7'd0);
    assign cc_exec = (status[7:4] == 4'hB);
    assign chosen  = match_found ? match_idx : (free_found ? free_idx : old_idx);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= NO_STATUS;
            status        <= '0;
            d1            <= '0;
            d2            <= '0;
            scan_idx      <= '0;
            match_found   <= 1'b0;
            free_found    <= 1'b0;
            match_idx     <= '0;
            free_idx      <= '0;
            old_idx       <= '0;
            old_age       <= '0;
            busy          <= 1'b0;
            overflow      <= 1'b0;
            voice_active  <= '0;
            voice_trigger <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                age_q[i]  <= '0;
            end
`ifdef SUSTAIN_PEDAL_EN
            pedal_down <= 1'b0;
            sustained  <= '0;
`endif
        end else begin
            overflow      <= 1'b0;
            voice_trigger <= '0;
            if (state == EXEC) begin
                if (byte_valid && midi_byte < 8'hF8)
                    overflow <= 1'b1;
                if (scan_idx != SCAN_DONE) begin
                    if (!match_found && voice_active[scan_v] && note_q[scan_v] == d1) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_v;
                    end
                    if (!free_found && !voice_active[scan_v]) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_v;
                    end
                    // Strict compare keeps the lowest index on equal ages.
                    if (age_q[scan_v] > old_age) begin
                        old_age <= age_q[scan_v];
                        old_idx <= scan_v;
                    end
                    scan_idx <= scan_idx + 1'b1;
                end else begin
`ifdef SUSTAIN_PEDAL_EN
                    if (cc_exec) begin
                        pedal_down <= d2[6];
                        if (!d2[6]) begin
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (sustained[i]) begin
                                    voice_active[i] <= 1'b0;
                                    age_q[i]        <= '0;
                                end
                            end
                            sustained <= '0;
                        end
                    end else
`endif
                    if (note_on) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (VIDX_W'(i) == chosen) begin
                                voice_active[i]  <= 1'b1;
                                note_q[i]        <= d1;
                                vel_q[i]         <= d2;
                                age_q[i]         <= '0;
                                voice_trigger[i] <= 1'b1;
`ifdef SUSTAIN_PEDAL_EN
                                sustained[i]     <= 1'b0;
`endif
                            end else if (voice_active[i] && age_q[i] != AGE_MAX) begin
                                age_q[i] <= age_q[i] + 1'b1;
                            end
                        end
                    end else begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (voice_active[i] && note_q[i] == d1) begin
`ifdef SUSTAIN_PEDAL_EN
                                if (pedal_down) sustained[i] <= 1'b1;
                                else begin
`else
                                begin
`endif
                                    voice_active[i] <= 1'b0;
                                    age_q[i]        <= '0;
                                end
                            end
                        end
                    end
                    busy  <= 1'b0;
                    state <= WAIT_D1;
                end
            end else if (byte_valid && midi_byte < 8'hF8) begin
                if (midi_byte >= 8'hF0) begin
                    status <= '0;
                    state  <= NO_STATUS;
                end else if (midi_byte[7]) begin
                    status <= midi_byte;
                    state  <= WAIT_D1;
                end else begin
                    case (state)
                        WAIT_D1: begin
                            d1 <= midi_byte[6:0];
                            // 0xCn/0xDn carry one data byte: complete, discarded.
                            if (status[7:5] != 3'b110)
                                state <= WAIT_D2;
                        end
                        WAIT_D2: begin
                            d2          <= midi_byte[6:0];
                            scan_idx    <= '0;
                            match_found <= 1'b0;
                            free_found  <= 1'b0;
                            old_idx     <= '0;
                            old_age     <= '0;
                            if (status == {4'h9, CH} || status == {4'h8, CH}) begin
                                state <= EXEC;
                                busy  <= 1'b1;
                            end
`ifdef SUSTAIN_PEDAL_EN
                            else if (status == {4'hB, CH} && d1 == 7'd64) begin
                                state    <= EXEC;
                                busy     <= 1'b1;
                                scan_idx <= SCAN_DONE;
                            end
`endif
                            else begin
                                state <= WAIT_D1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign voice_note[7*g +: 7]     = note_q[g];
        assign voice_velocity[7*g +: 7] = vel_q[g];
    end

endmodule

// File: tb/tb_midi_voice_allocator.sv
module tb_midi_voice_allocator;
    localparam int NV = 8;
    localparam logic [3:0] CH = 4'd0;

    logic            clock;
    logic            reset;
    logic            byte_valid;
    logic [7:0]      midi_byte;
    logic            busy;
    logic            overflow;
    logic [NV-1:0]   voice_active;
    logic [7*NV-1:0] voice_note;
    logic [7*NV-1:0] voice_velocity;
    logic [NV-1:0]   voice_trigger;

    int checks = 0;
    int errors = 0;

    midi_voice_allocator #(.NUM_VOICES(NV), .CHANNEL(0)) dut (
        .clock(clock), .reset(reset), .byte_valid(byte_valid), .midi_byte(midi_byte),
        .busy(busy), .overflow(overflow), .voice_active(voice_active),
        .voice_note(voice_note), .voice_velocity(voice_velocity),
        .voice_trigger(voice_trigger)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: voices with allocation timestamps; age is derived
    // as allocations since the voice was last allocated, saturated.
    logic          m_active [NV];
    logic          m_sus    [NV];
    logic [6:0]    m_note   [NV];
    logic [6:0]    m_vel    [NV];
    int            m_stamp  [NV];
    int            m_count;
    logic [7:0]    m_status;
    int            m_need;
    logic [6:0]    m_d1;
    logic          m_pedal;
    logic [NV-1:0] m_trig;

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_active[i] = 0; m_sus[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_stamp[i] = 0;
        end
        m_count = 0; m_status = 0; m_need = 0; m_d1 = 0; m_pedal = 0; m_trig = '0;
    endtask

    function automatic int m_age(input int i);
        int a;
        a = m_count - m_stamp[i];
        return (a > NV - 1) ? NV - 1 : a;
    endfunction

    task automatic model_note_on(input logic [6:0] n, input logic [6:0] v);
        int ch;
        int best;
        ch = -1;
        for (int i = 0; i < NV; i++)
            if (ch < 0 && m_active[i] && m_note[i] == n) ch = i;
        for (int i = 0; i < NV; i++)
            if (ch < 0 && !m_active[i]) ch = i;
        if (ch < 0) begin
            best = -1;
            for (int i = 0; i < NV; i++)
                if (m_age(i) > best) begin best = m_age(i); ch = i; end
        end
        m_count++;
        m_stamp[ch] = m_count;
        m_active[ch] = 1; m_sus[ch] = 0; m_note[ch] = n; m_vel[ch] = v;
        m_trig[ch] = 1'b1;
    endtask

    task automatic model_note_off(input logic [6:0] n);
        for (int i = 0; i < NV; i++)
            if (m_active[i] && m_note[i] == n) begin
                if (m_pedal) m_sus[i] = 1;
                else m_active[i] = 0;
            end
    endtask

    task automatic model_pedal(input logic down);
        m_pedal = down;
        if (!down)
            for (int i = 0; i < NV; i++)
                if (m_sus[i]) begin m_active[i] = 0; m_sus[i] = 0; end
    endtask

    task automatic model_byte(input logic [7:0] b, output int exp_busy);
        exp_busy = 0;
        m_trig = '0;
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin m_status = 0; m_need = 0; return; end
        if (b[7]) begin m_status = b; m_need = 1; return; end
        if (m_need == 0) return;
        if (m_need == 1) begin
            m_d1 = b[6:0];
            if (m_status[7:4] != 4'hC && m_status[7:4] != 4'hD) m_need = 2;
            return;
        end
        m_need = 1;
        if (m_status == {4'h9, CH} && b != 8'h00) begin
            model_note_on(m_d1, b[6:0]); exp_busy = NV + 1;
        end else if (m_status == {4'h9, CH} || m_status == {4'h8, CH}) begin
            model_note_off(m_d1); exp_busy = NV + 1;
        end
`ifdef SUSTAIN_PEDAL_EN
        else if (m_status == {4'hB, CH} && m_d1 == 7'd64) begin
            model_pedal(b >= 8'd64); exp_busy = 1;
        end
`endif
    endtask

    function automatic logic [NV-1:0] e_active();
        logic [NV-1:0] r;
        for (int i = 0; i < NV; i++) r[i] = m_active[i];
        return r;
    endfunction

    function automatic logic [7*NV-1:0] e_note();
        logic [7*NV-1:0] r;
        for (int i = 0; i < NV; i++) r[7*i +: 7] = m_note[i];
        return r;
    endfunction

    function automatic logic [7*NV-1:0] e_vel();
        logic [7*NV-1:0] r;
        for (int i = 0; i < NV; i++) r[7*i +: 7] = m_vel[i];
        return r;
    endfunction

    // All drivers are entered and left on a falling edge.
    task automatic drive_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        midi_byte  = b;
        @(negedge clock);
        byte_valid = 1'b0;
        midi_byte  = 8'h00;
    endtask

    task automatic wait_idle(output int busy_cyc);
        busy_cyc = 0;
        while (busy === 1'b1 && busy_cyc < 64) begin
            busy_cyc++;
            @(negedge clock);
        end
    endtask

    task automatic send(input logic [7:0] b, output int exp_busy, output int busy_cyc);
        drive_byte(b);
        model_byte(b, exp_busy);
        wait_idle(busy_cyc);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (voice_active !== '0 || voice_note !== '0 || voice_velocity !== '0) begin
            errors++;
            $display("FAIL reset_voices: active=%h note=%h vel=%h, need all 0", voice_active, voice_note, voice_velocity);
        end
        checks++;
        if (busy !== 1'b0 || overflow !== 1'b0 || voice_trigger !== '0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b overflow=%b trig=%h, need 0", busy, overflow, voice_trigger);
        end
    endtask

    task automatic test_single_note();
        int eb, bc;
        do_reset();
        send(8'h90, eb, bc);
        send(8'h3C, eb, bc);
        send(8'h64, eb, bc);
        checks++;
        if (bc !== eb) begin errors++; $display("FAIL single_busy: got %0d cycles, need %0d", bc, eb); end
        checks++;
        if (voice_active !== e_active() || voice_note !== e_note() || voice_velocity !== e_vel()) begin
            errors++;
            $display("FAIL single_voice: active=%h note=%h vel=%h, need %h %h %h", voice_active, voice_note, voice_velocity, e_active(), e_note(), e_vel());
        end
        checks++;
        if (voice_trigger !== m_trig) begin errors++; $display("FAIL single_trig: got %h, need %h", voice_trigger, m_trig); end
        @(negedge clock);
        checks++;
        if (voice_trigger !== '0) begin errors++; $display("FAIL single_trig_pulse: got %h, need 0", voice_trigger); end
    endtask

    task automatic test_running_status();
        int eb, bc;
        do_reset();
        send(8'h90, eb, bc); send(8'h3C, eb, bc); send(8'h64, eb, bc);
        send(8'h40, eb, bc); send(8'h50, eb, bc);
        checks++;
        if (bc !== eb || voice_trigger !== m_trig || voice_note !== e_note()) begin
            errors++;
            $display("FAIL running_on: busy=%0d trig=%h note=%h, need %0d %h %h", bc, voice_trigger, voice_note, eb, m_trig, e_note());
        end
        send(8'h3C, eb, bc); send(8'h00, eb, bc);
        checks++;
        if (voice_active !== e_active() || voice_trigger !== '0) begin
            errors++;
            $display("FAIL running_off: active=%h trig=%h, need %h 0", voice_active, voice_trigger, e_active());
        end
    endtask

    task automatic test_steal();
        int eb, bc;
        do_reset();
        send(8'h90, eb, bc);
        for (int n = 60; n < 68; n++) begin
            send(8'(n), eb, bc);
            send(8'h40, eb, bc);
        end
        checks++;
        if (voice_active !== e_active() || voice_note !== e_note()) begin
            errors++;
            $display("FAIL steal_fill: active=%h note=%h, need %h %h", voice_active, voice_note, e_active(), e_note());
        end
        send(8'd70, eb, bc); send(8'h22, eb, bc);
        checks++;
        if (voice_trigger !== m_trig || voice_note !== e_note() || voice_active !== e_active()) begin
            errors++;
            $display("FAIL steal_oldest: trig=%h note=%h active=%h, need %h %h %h", voice_trigger, voice_note, voice_active, m_trig, e_note(), e_active());
        end
        send(8'd61, eb, bc); send(8'h11, eb, bc);
        checks++;
        if (voice_trigger !== m_trig || voice_velocity !== e_vel() || voice_note !== e_note()) begin
            errors++;
            $display("FAIL steal_retrig: trig=%h vel=%h note=%h, need %h %h %h", voice_trigger, voice_velocity, voice_note, m_trig, e_vel(), e_note());
        end
    endtask

    task automatic test_realtime_channel();
        int eb, bc;
        do_reset();
        send(8'h90, eb, bc); send(8'hF8, eb, bc); send(8'h3C, eb, bc);
        send(8'hFE, eb, bc); send(8'h64, eb, bc);
        checks++;
        if (bc !== eb || voice_active !== e_active() || voice_note !== e_note()) begin
            errors++;
            $display("FAIL realtime: busy=%0d active=%h note=%h, need %0d %h %h", bc, voice_active, voice_note, eb, e_active(), e_note());
        end
        send(8'h95, eb, bc); send(8'h30, eb, bc); send(8'h40, eb, bc);
        checks++;
        if (bc !== eb || voice_active !== e_active() || voice_note !== e_note()) begin
            errors++;
            $display("FAIL other_channel: busy=%0d active=%h note=%h, need %0d %h %h", bc, voice_active, voice_note, eb, e_active(), e_note());
        end
        send(8'hB0, eb, bc); send(8'h40, eb, bc); send(8'h7F, eb, bc);
        checks++;
        if (bc !== eb) begin errors++; $display("FAIL control_change_busy: got %0d, need %0d", bc, eb); end
        send(8'hC0, eb, bc); send(8'h10, eb, bc); send(8'h22, eb, bc);
        send(8'h90, eb, bc); send(8'h3C, eb, bc); send(8'h00, eb, bc);
        checks++;
        if (bc !== eb || voice_active !== e_active()) begin
            errors++;
            $display("FAIL vel0_off: busy=%0d active=%h, need %0d %h", bc, voice_active, eb, e_active());
        end
    endtask

    task automatic test_overflow();
        int eb, bc;
        do_reset();
        send(8'h90, eb, bc); send(8'h3C, eb, bc);
        drive_byte(8'h64);
        model_byte(8'h64, eb);
        drive_byte(8'hF8);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_realtime: got %b, need 0", overflow); end
        drive_byte(8'h45);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_pulse: got %b, need 1", overflow); end
        @(negedge clock);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_width: got %b, need 0", overflow); end
        wait_idle(bc);
        checks++;
        if (voice_active !== e_active() || voice_note !== e_note() || voice_trigger !== m_trig) begin
            errors++;
            $display("FAIL overflow_event: active=%h note=%h trig=%h, need %h %h %h", voice_active, voice_note, voice_trigger, e_active(), e_note(), m_trig);
        end
        send(8'h3E, eb, bc); send(8'h40, eb, bc);
        checks++;
        if (bc !== eb || voice_active !== e_active() || voice_note !== e_note()) begin
            errors++;
            $display("FAIL overflow_next: busy=%0d active=%h note=%h, need %0d %h %h", bc, voice_active, voice_note, eb, e_active(), e_note());
        end
    endtask

    task automatic test_reset_mid_scan();
        int eb, bc;
        int bad;
        do_reset();
        drive_byte(8'h90); drive_byte(8'h3C); drive_byte(8'h64);
        repeat (3) @(negedge clock);
        do_reset();
        checks++;
        if (busy !== 1'b0 || voice_active !== '0 || voice_note !== '0 || voice_velocity !== '0 || voice_trigger !== '0) begin
            errors++;
            $display("FAIL midscan_reset: busy=%b active=%h note=%h trig=%h, need 0", busy, voice_active, voice_note, voice_trigger);
        end
        bad = 0;
        for (int c = 0; c < NV + 3; c++) begin
            if (voice_trigger !== '0 || voice_active !== '0) bad++;
            @(negedge clock);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL midscan_quiet: %0d cycles with activity, need 0", bad); end
        send(8'h3C, eb, bc); send(8'h64, eb, bc);
        checks++;
        if (bc !== eb || voice_active !== e_active()) begin
            errors++;
            $display("FAIL midscan_no_status: busy=%0d active=%h, need %0d %h", bc, voice_active, eb, e_active());
        end
    endtask

`ifdef SUSTAIN_PEDAL_EN
    task automatic test_sustain();
        int eb, bc;
        do_reset();
        send(8'hB0, eb, bc); send(8'h40, eb, bc); send(8'h7F, eb, bc);
        checks++;
        if (bc !== eb) begin errors++; $display("FAIL pedal_busy: got %0d, need %0d", bc, eb); end
        send(8'h90, eb, bc); send(8'h3C, eb, bc); send(8'h64, eb, bc);
        send(8'h80, eb, bc); send(8'h3C, eb, bc); send(8'h40, eb, bc);
        checks++;
        if (voice_active !== e_active()) begin errors++; $display("FAIL pedal_hold: active=%h, need %h", voice_active, e_active()); end
        send(8'hB0, eb, bc); send(8'h40, eb, bc); send(8'h00, eb, bc);
        checks++;
        if (voice_active !== e_active()) begin errors++; $display("FAIL pedal_release: active=%h, need %h", voice_active, e_active()); end
    endtask
`endif

    task automatic test_random();
        logic [7:0] msg [6];
        int len, r, eb, bc;
        do_reset();
        for (int it = 0; it < 250; it++) begin
            len = 0;
            r = $urandom_range(0, 99);
            if (r < 65) begin
                if ($urandom_range(0, 9) < 7) begin msg[len] = (r < 45) ? 8'h90 : 8'h80; len++; end
                msg[len] = 8'($urandom_range(60, 71)); len++;
                msg[len] = ($urandom_range(0, 6) == 0) ? 8'h00 : 8'($urandom_range(1, 127)); len++;
            end else if (r < 72) begin
                msg[0] = {($urandom_range(0, 1) == 0) ? 4'h9 : 4'h8, 4'($urandom_range(1, 15))};
                msg[1] = 8'($urandom_range(60, 71)); msg[2] = 8'($urandom_range(1, 127)); len = 3;
            end else if (r < 78) begin
                msg[0] = 8'hC0; msg[1] = 8'($urandom_range(0, 127)); len = 2;
            end else if (r < 86) begin
                msg[0] = 8'hB0; msg[1] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 127)) : 8'd64;
                msg[2] = 8'($urandom_range(0, 127)); len = 3;
            end else if (r < 90) begin
                msg[0] = 8'hF0; msg[1] = 8'($urandom_range(0, 127)); msg[2] = 8'hF7; len = 3;
            end else begin
                msg[0] = 8'($urandom_range(248, 255)); len = 1;
            end
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 9) == 0) begin
                    send(8'($urandom_range(248, 255)), eb, bc);
                end
                send(msg[k], eb, bc);
                checks++;
                if (bc !== eb || voice_trigger !== m_trig) begin
                    errors++;
                    $display("FAIL rand_timing it=%0d byte=%h: busy=%0d trig=%h, need %0d %h", it, msg[k], bc, voice_trigger, eb, m_trig);
                end
                checks++;
                if (voice_active !== e_active() || voice_note !== e_note() || voice_velocity !== e_vel()) begin
                    errors++;
                    $display("FAIL rand_voices it=%0d byte=%h: active=%h note=%h vel=%h, need %h %h %h", it, msg[k], voice_active, voice_note, voice_velocity, e_active(), e_note(), e_vel());
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        byte_valid = 1'b0;
        midi_byte  = 8'h00;
        model_reset();
        repeat (3) @(negedge clock);
        test_reset();
        test_single_note();
        test_running_status();
        test_steal();
        test_realtime_channel();
        test_overflow();
        test_reset_mid_scan();
`ifdef SUSTAIN_PEDAL_EN
        test_sustain();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
